// File: rtl/pipelined_barrel_shifter_if.sv
// pipelined_barrel_shifter_if: operand/control inputs and qualified result outputs of the shifter
interface pipelined_barrel_shifter_if #(parameter int SW = 26, parameter int EW = 5);
  logic en;
  logic valid;
  logic [SW-1:0] data;
  logic left_right;
  logic [1:0] mode;
  logic [EW-1:0] shift_value;
  logic res_valid;
  logic [SW-1:0] result;
  logic sticky;
  modport master (
    output en, valid, data, left_right, mode, shift_value,
    input res_valid, result, sticky
  );
  modport slave (
    input en, valid, data, left_right, mode, shift_value,
    output res_valid, result, sticky
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: log-level right shifter with logical/arith/rotate modes and sticky, registered every GROUP levels
module pipelined_barrel_shifter #(
  parameter int SW = 26,
  parameter int EW = 5,
  parameter int GROUP = 2
) (
  input logic clk,
  input logic rst,
  pipelined_barrel_shifter_if.slave bus
);
  typedef struct packed {
    logic v;
    logic l;
    logic r;
    logic f;
    logic [EW-1:0] s;
  } sb_t;
  function automatic logic [SW-1:0] rev(input logic [SW-1:0] x);
    logic [SW-1:0] y;
    for (int i = 0; i < SW; i++) y[i] = x[SW-1-i];
    return y;
  endfunction
  logic [SW-1:0] d0;
  sb_t s0;
  logic [SW-1:0] dq [EW];
  sb_t sq [EW];
  logic tq [EW];
  // fill bit is the sign only for arithmetic right; reserved mode falls through as logical
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      d0 <= '0;
      s0 <= '0;
    end else if (bus.en) begin
      d0 <= bus.left_right ? rev(bus.data) : bus.data;
      s0 <= {bus.valid, bus.left_right, bus.mode == 2'b10,
             bus.mode == 2'b01 && !bus.left_right && bus.data[SW-1], bus.shift_value};
    end
  for (genvar k = 0; k < EW; k++) begin : g_lvl
    localparam int S = 1 << k;
    localparam int R = S % SW;
    logic [SW-1:0] di, sh, ro;
    sb_t si;
    logic ti, so;
    if (k == 0) begin : g_in0
      assign di = d0;
      assign si = s0;
      assign ti = 1'b0;
    end else if (k % GROUP == 0) begin : g_reg
      always_ff @(posedge clk or negedge rst)
        if (!rst) begin
          di <= '0;
          si <= '0;
          ti <= 1'b0;
        end else if (bus.en) begin
          di <= dq[k-1];
          si <= sq[k-1];
          ti <= tq[k-1];
        end
    end else begin : g_wire
      assign di = dq[k-1];
      assign si = sq[k-1];
      assign ti = tq[k-1];
    end
    // a level whose step reaches the width saturates to fill instead of wrapping
    if (S >= SW) begin : g_sat
      assign sh = {SW{si.f}};
      assign so = |di;
    end else begin : g_part
      assign sh = {{S{si.f}}, di[SW-1:S]};
      assign so = |di[S-1:0];
    end
    if (R == 0) begin : g_r0
      assign ro = di;
    end else begin : g_rn
      assign ro = {di[R-1:0], di[SW-1:R]};
    end
    assign dq[k] = !si.s[k] ? di : si.r ? ro : sh;
    assign sq[k] = si;
    assign tq[k] = ti | (si.s[k] & !si.r & so);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus.res_valid <= 1'b0;
      bus.result <= '0;
      bus.sticky <= 1'b0;
    end else if (bus.en) begin
      bus.res_valid <= sq[EW-1].v;
      bus.result <= sq[EW-1].l ? rev(dq[EW-1]) : dq[EW-1];
      bus.sticky <= tq[EW-1] & !sq[EW-1].l;
    end
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: directed and random checks against an arithmetic reference and a delay-line latency model
module tb_pipelined_barrel_shifter;
  localparam int SW = 26;
  localparam int EW = 5;
  localparam int L = 4;
  typedef struct packed {
    logic v;
    logic [SW-1:0] d;
    logic s;
  } res_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  pipelined_barrel_shifter_if #(.SW(SW), .EW(EW)) bus ();
  pipelined_barrel_shifter #(.SW(SW), .EW(EW), .GROUP(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  res_t pipe[$];
  res_t exp_o;
  int vectors = 0;
  int miscompares = 0;
  function automatic res_t model(input logic v, input logic [SW-1:0] d, input logic l,
                                 input logic [1:0] m, input logic [EW-1:0] sh);
    logic [63:0] x, mask;
    int n, k;
    res_t r;
    x = 64'(d);
    mask = (64'd1 << SW) - 64'd1;
    n = int'(sh);
    r.v = v;
    r.s = 1'b0;
    if (m == 2'b10) begin
      k = n % SW;
      x = l ? ((x << k) | (x >> (SW - k))) : ((x >> k) | (x << (SW - k)));
    end else if (l) begin
      x = (n >= SW) ? 64'd0 : (x << n);
    end else begin
      r.s = (n >= SW) ? (d != '0) : ((x & ((64'd1 << n) - 64'd1)) != 64'd0);
      if (m == 2'b01 && d[SW-1]) x = (n >= SW) ? mask : ((x >> n) | (mask & ~(mask >> n)));
      else x = (n >= SW) ? 64'd0 : (x >> n);
    end
    r.d = SW'(x & mask);
    return r;
  endfunction
  task automatic cmp(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask
  task automatic check_out(input string tag);
    cmp({tag, ".valid"}, SW'(bus.res_valid), SW'(exp_o.v));
    cmp({tag, ".data"}, bus.result, exp_o.d);
    cmp({tag, ".sticky"}, SW'(bus.sticky), SW'(exp_o.s));
  endtask
  task automatic flush_model();
    pipe.delete();
    repeat (L - 1) pipe.push_back('0);
    exp_o = '0;
  endtask
  task automatic step(input logic e, input logic v, input logic [SW-1:0] d, input logic l,
                      input logic [1:0] m, input logic [EW-1:0] sh, input string tag);
    bus.en = e;
    bus.valid = v;
    bus.data = d;
    bus.left_right = l;
    bus.mode = m;
    bus.shift_value = sh;
    @(posedge clk);
    if (e) begin
      pipe.push_back(model(v, d, l, m, sh));
      exp_o = pipe.pop_front();
    end
    #1 check_out(tag);
  endtask
  task automatic idle(input int n, input string tag);
    repeat (n) step(1'b1, 1'b0, '0, 1'b0, 2'b00, '0, tag);
  endtask
  task automatic directed(input logic [SW-1:0] d, input logic l, input logic [1:0] m,
                          input logic [EW-1:0] sh, input logic [SW-1:0] want_d,
                          input logic want_s, input string tag);
    step(1'b1, 1'b1, d, l, m, sh, tag);
    idle(L - 1, tag);
    cmp({tag, ".k_valid"}, SW'(bus.res_valid), SW'(1));
    cmp({tag, ".k_data"}, bus.result, want_d);
    cmp({tag, ".k_sticky"}, SW'(bus.sticky), SW'(want_s));
  endtask
  initial begin
    bus.en = 1'b0;
    bus.valid = 1'b0;
    bus.data = '0;
    bus.left_right = 1'b0;
    bus.mode = 2'b00;
    bus.shift_value = '0;
    flush_model();
    repeat (3) @(posedge clk);
    #1 check_out("reset");
    rst = 1'b1;
    directed(26'h0000001, 1'b1, 2'b00, 5'd5, 26'h0000020, 1'b0, "latency");
    idle(2, "latency_tail");
    directed(26'h2000003, 1'b0, 2'b01, 5'd2, 26'h3800000, 1'b1, "arith_right");
    directed(26'h2000003, 1'b0, 2'b00, 5'd2, 26'h0800000, 1'b1, "logic_right");
    directed(26'h0000001, 1'b0, 2'b10, 5'd27, 26'h2000000, 1'b0, "rot_wrap");
    directed(26'h1234567, 1'b1, 2'b10, 5'd26, 26'h1234567, 1'b0, "rot_left26");
    directed(26'h3FFFFFF, 1'b0, 2'b00, 5'd31, 26'h0000000, 1'b1, "sat_logic");
    directed(26'h3FFFFFF, 1'b0, 2'b01, 5'd31, 26'h3FFFFFF, 1'b1, "sat_arith");
    directed(26'h2ABCDEF, 1'b1, 2'b01, 5'd4, 26'h2BCDEF0, 1'b0, "arith_left");
    directed(26'h00000F0, 1'b0, 2'b11, 5'd4, 26'h000000F, 1'b0, "reserved");
    directed(26'h00000FF, 1'b0, 2'b00, 5'd0, 26'h00000FF, 1'b0, "zero_shift");
    step(1'b1, 1'b1, 26'h2F0F0F1, 1'b0, 2'b01, 5'd7, "b2b");
    step(1'b1, 1'b1, 26'h1A5A5A5, 1'b1, 2'b00, 5'd9, "b2b");
    step(1'b1, 1'b1, 26'h3C3C3C3, 1'b0, 2'b10, 5'd30, "b2b");
    step(1'b1, 1'b1, 26'h0FFF001, 1'b0, 2'b00, 5'd13, "b2b");
    repeat (3) step(1'b0, 1'b1, 26'h3FFFFFF, 1'b1, 2'b10, 5'd3, "stall");
    idle(L + 1, "b2b_drain");
    step(1'b1, 1'b1, 26'h3FFFFFF, 1'b0, 2'b00, 5'd3, "midrst");
    step(1'b1, 1'b1, 26'h2000000, 1'b0, 2'b01, 5'd1, "midrst");
    bus.data = 26'h1111111;
    bus.shift_value = 5'd2;
    #3 rst = 1'b0;
    flush_model();
    #1 check_out("rst_async");
    repeat (2) begin
      @(posedge clk);
      #1 check_out("rst_hold");
    end
    rst = 1'b1;
    idle(L + 2, "post_rst");
    directed(26'h0000003, 1'b1, 2'b00, 5'd24, 26'h3000000, 1'b0, "post_rst_op");
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 7) != 0, 1'($urandom), SW'($urandom), 1'($urandom),
           2'($urandom), EW'($urandom), "random");
    idle(L, "final_drain");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
